// File: rtl/cpu_bus_if.sv
// cpu_bus_if: memory read bus between the CPU (master) and program memory (slave).
interface cpu_bus_if;
    logic [7:0] DATA_IN_BUS;
    logic [7:0] ADDR_OUT_BUS;
    modport master (input DATA_IN_BUS, output ADDR_OUT_BUS);
    modport slave (output DATA_IN_BUS, input ADDR_OUT_BUS);
endinterface

// File: rtl/cpu_top.sv
// cpu_top: 8-bit accumulator CPU with FETCH/OPERAND/MEM/EXEC phases and a read-only memory bus.
module cpu_top (
    input logic clk,
    input logic reset,
    cpu_bus_if.master bus
);
    typedef enum logic [1:0] {FETCH, OPERAND, MEM, EXEC} phase_t;
    phase_t phase, phase_nxt;
    logic [7:0] pc, ir, mar, A_REG, a_nxt, din;
    logic [8:0] alu;
    logic z, c, a_we, c_we;
    assign din = bus.DATA_IN_BUS;
    always_ff @(posedge clk or negedge reset)
        if (!reset) phase <= FETCH;
        else phase <= phase_nxt;
    always_comb begin
        phase_nxt = FETCH;
        case (phase)
            FETCH: phase_nxt = (din >= 8'h01 && din <= 8'h07) ? OPERAND : EXEC;
            OPERAND: phase_nxt = (ir == 8'h02) ? MEM : FETCH;
            default: phase_nxt = FETCH;
        endcase
    end
    assign bus.ADDR_OUT_BUS = (phase == MEM) ? mar : pc;
    // Bit 8 of the ALU result is carry for ADD and borrow for SUB.
    always_comb begin
        alu = (ir == 8'h03) ? {1'b0, A_REG} - {1'b0, din} : {1'b0, A_REG} + {1'b0, din};
        a_we = (phase == MEM) || (phase == OPERAND && ir inside {8'h01, 8'h03, 8'h04, 8'h06, 8'h07});
        c_we = (phase == OPERAND) && (ir == 8'h01 || ir == 8'h03);
        a_nxt = (phase == MEM || ir == 8'h04) ? din :
                (ir == 8'h06) ? (A_REG & din) :
                (ir == 8'h07) ? (A_REG | din) : alu[7:0];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 8'h00;
            ir <= 8'h00;
            mar <= 8'h00;
            A_REG <= 8'h00;
            z <= 1'b0;
            c <= 1'b0;
        end else begin
            if (phase == FETCH) begin
                ir <= din;
                pc <= pc + 8'd1;
            end else if (phase == OPERAND) begin
                pc <= (ir == 8'h05) ? din : pc + 8'd1;
                if (ir == 8'h02) mar <= din;
            end
            if (a_we) begin
                A_REG <= a_nxt;
                z <= (a_nxt == 8'h00);
            end
            if (c_we) c <= alu[8];
        end
    end
endmodule

// File: tb/tb_cpu_top.sv
// tb_cpu_top: directed and randomized checks of cpu_top against an instruction-level model.
module tb_cpu_top;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [7:0] mem [256];
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] m_pc, m_a;
    logic m_z, m_c;
    cpu_bus_if bus ();
    assign bus.DATA_IN_BUS = mem[bus.ADDR_OUT_BUS];
    cpu_top dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask
    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask
    task automatic do_reset;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask
    // Executes one whole instruction on the architectural model; returns its cycle count.
    task automatic ref_step(output int cyc, output logic [7:0] maddr);
        logic [7:0] op, opd;
        int r;
        op = mem[m_pc];
        m_pc = m_pc + 8'd1;
        cyc = 2;
        maddr = 8'h00;
        if (op >= 8'h01 && op <= 8'h07) begin
            opd = mem[m_pc];
            m_pc = m_pc + 8'd1;
            case (op)
                8'h01: begin r = int'(m_a) + int'(opd); m_c = (r > 255); m_a = 8'(r % 256); m_z = (m_a == 0); end
                8'h02: begin maddr = opd; cyc = 3; m_a = mem[opd]; m_z = (m_a == 0); end
                8'h03: begin r = int'(m_a) - int'(opd); m_c = (r < 0); m_a = 8'((r + 256) % 256); m_z = (m_a == 0); end
                8'h04: begin m_a = opd; m_z = (m_a == 0); end
                8'h05: m_pc = opd;
                8'h06: begin m_a = m_a & opd; m_z = (m_a == 0); end
                default: begin m_a = m_a | opd; m_z = (m_a == 0); end
            endcase
        end
    endtask
    task automatic test_reset;
        clear_mem();
        reset = 1'b1;
        mem[0] = 8'h04;
        mem[1] = 8'h99;
        tick(3);
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.ADDR_OUT_BUS !== 8'h00) begin n_errors++; $display("FAIL reset_addr: got %h expected 00", bus.ADDR_OUT_BUS); end
        n_checks++;
        if (dut.A_REG !== 8'h00 || dut.z !== 1'b0 || dut.c !== 1'b0) begin
            n_errors++; $display("FAIL reset_regs: A=%h Z=%b C=%b expected 00/0/0", dut.A_REG, dut.z, dut.c);
        end
    endtask
    task automatic test_directed;
        logic [7:0] exp_addr [9] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h2A, 8'h05, 8'h06};
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h02;
        mem[3] = 8'h02; mem[4] = 8'h2A; mem[8'h2A] = 8'h45;
        mem[5] = 8'h01; mem[6] = 8'h05;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (bus.ADDR_OUT_BUS !== exp_addr[i]) begin
                n_errors++; $display("FAIL dir_addr[%0d]: got %h expected %h", i, bus.ADDR_OUT_BUS, exp_addr[i]);
            end
            if (i == 4) begin
                n_checks++;
                if (dut.A_REG !== 8'h02) begin n_errors++; $display("FAIL dir_add: A=%h expected 02", dut.A_REG); end
            end
            if (i == 7) begin
                n_checks++;
                if (dut.A_REG !== 8'h45) begin n_errors++; $display("FAIL dir_lod: A=%h expected 45", dut.A_REG); end
            end
            tick();
        end
        n_checks++;
        if (dut.A_REG !== 8'h4A || bus.ADDR_OUT_BUS !== 8'h07) begin
            n_errors++; $display("FAIL dir_add2: A=%h addr=%h expected 4A/07", dut.A_REG, bus.ADDR_OUT_BUS);
        end
    endtask
    task automatic test_alu_flags;
        clear_mem();
        mem[0] = 8'h04; mem[1] = 8'hF0; mem[2] = 8'h01; mem[3] = 8'h20;
        mem[4] = 8'h03; mem[5] = 8'h10; mem[6] = 8'h06; mem[7] = 8'h00;
        do_reset();
        tick(2);
        n_checks++;
        if (dut.A_REG !== 8'hF0) begin n_errors++; $display("FAIL ldi: A=%h expected F0", dut.A_REG); end
        tick(2);
        n_checks++;
        if (dut.A_REG !== 8'h10 || dut.c !== 1'b1 || dut.z !== 1'b0) begin
            n_errors++; $display("FAIL add_carry: A=%h C=%b Z=%b expected 10/1/0", dut.A_REG, dut.c, dut.z);
        end
        tick(2);
        n_checks++;
        if (dut.A_REG !== 8'h00 || dut.c !== 1'b0 || dut.z !== 1'b1) begin
            n_errors++; $display("FAIL sub_zero: A=%h C=%b Z=%b expected 00/0/1", dut.A_REG, dut.c, dut.z);
        end
    endtask
    task automatic test_jmp_wrap;
        clear_mem();
        mem[0] = 8'h05; mem[1] = 8'h80; mem[8'h80] = 8'h05; mem[8'h81] = 8'hFF; mem[8'hFF] = 8'h00;
        do_reset();
        tick(2);
        n_checks++;
        if (bus.ADDR_OUT_BUS !== 8'h80) begin n_errors++; $display("FAIL jmp: addr=%h expected 80", bus.ADDR_OUT_BUS); end
        tick(2);
        n_checks++;
        if (bus.ADDR_OUT_BUS !== 8'hFF) begin n_errors++; $display("FAIL jmp_ff: addr=%h expected FF", bus.ADDR_OUT_BUS); end
        tick(2);
        n_checks++;
        if (bus.ADDR_OUT_BUS !== 8'h00) begin n_errors++; $display("FAIL pc_wrap: addr=%h expected 00", bus.ADDR_OUT_BUS); end
        clear_mem();
        mem[0] = 8'h05; mem[1] = 8'hFE; mem[8'hFE] = 8'h04; mem[8'hFF] = 8'h5A;
        do_reset();
        tick(4);
        n_checks++;
        if (dut.A_REG !== 8'h5A || bus.ADDR_OUT_BUS !== 8'h00) begin
            n_errors++; $display("FAIL operand_wrap: A=%h addr=%h expected 5A/00", dut.A_REG, bus.ADDR_OUT_BUS);
        end
    endtask
    task automatic test_reset_mid_lod;
        clear_mem();
        mem[0] = 8'h04; mem[1] = 8'h11; mem[2] = 8'h02; mem[3] = 8'h2A; mem[8'h2A] = 8'h77;
        do_reset();
        tick(4);
        n_checks++;
        if (bus.ADDR_OUT_BUS !== 8'h2A || dut.A_REG !== 8'h11) begin
            n_errors++; $display("FAIL lod_mem: addr=%h A=%h expected 2A/11", bus.ADDR_OUT_BUS, dut.A_REG);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.ADDR_OUT_BUS !== 8'h00 || dut.A_REG !== 8'h00) begin
            n_errors++; $display("FAIL mid_reset: addr=%h A=%h expected 00/00", bus.ADDR_OUT_BUS, dut.A_REG);
        end
        tick();
        n_checks++;
        if (dut.A_REG !== 8'h00) begin n_errors++; $display("FAIL mid_reset_hold: A=%h expected 00", dut.A_REG); end
        reset = 1'b1;
    endtask
    task automatic test_random;
        int cyc;
        logic [7:0] maddr, op;
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
        do_reset();
        m_pc = 8'h00; m_a = 8'h00; m_z = 1'b0; m_c = 1'b0;
        for (int k = 0; k < 400; k++) begin
            n_checks++;
            if (bus.ADDR_OUT_BUS !== m_pc) begin
                n_errors++; $display("FAIL rnd_fetch[%0d]: addr=%h expected %h", k, bus.ADDR_OUT_BUS, m_pc);
            end
            op = mem[m_pc];
            ref_step(cyc, maddr);
            if (op == 8'h02) begin
                tick(2);
                n_checks++;
                if (bus.ADDR_OUT_BUS !== maddr) begin
                    n_errors++; $display("FAIL rnd_mem[%0d]: addr=%h expected %h", k, bus.ADDR_OUT_BUS, maddr);
                end
                tick(cyc - 2);
            end else tick(cyc);
            n_checks++;
            if (dut.A_REG !== m_a || dut.z !== m_z || dut.c !== m_c) begin
                n_errors++;
                $display("FAIL rnd_state[%0d] op=%h: A=%h Z=%b C=%b expected %h/%b/%b", k, op, dut.A_REG, dut.z, dut.c, m_a, m_z, m_c);
            end
        end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_alu_flags();
        test_jmp_wrap();
        test_reset_mid_lod();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cpu_top.md
CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 Clocking SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 DATA_IN_BUS  input  8  memory read data; sampled on the rising edge ending each cycle.
REQ-005 ADDR_OUT_BUS  output  8  memory address; combinational from state/PC/MAR, valid for the whole cycle.
REQ-006 The accumulator SHALL be an 8-bit register named A_REG, reachable hierarchically by the bench.
REQ-007 The design SHALL have no parameters.

Function
REQ-008 Internal state SHALL be PC[7:0], IR[7:0], MAR[7:0], A_REG[7:0], flags Z and C, and phase FETCH/OPERAND/MEM/EXEC.
REQ-009 ADDR_OUT_BUS SHALL equal MAR in MEM and PC in every other phase.
REQ-010 FETCH: IR<=DATA_IN_BUS, PC<=PC+1; next phase OPERAND for opcodes 0x01-0x07, otherwise EXEC.
REQ-011 NOP (0x00) and undefined opcodes (0x08-0xFF): FETCH then EXEC with no state change besides PC; 2 cycles total.
REQ-012 ADD A,imm (0x01), 2 cycles: OPERAND reads imm at PC; A<=A+imm mod 256; C=carry out; PC<=PC+1.
REQ-013 LOD A,[addr] (0x02), 3 cycles: OPERAND: MAR<=DATA_IN_BUS, PC<=PC+1; MEM: ADDR_OUT=MAR, A<=DATA_IN_BUS.
REQ-014 SUB A,imm (0x03), 2 cycles: A<=A-imm mod 256; C=1 on borrow; PC<=PC+1.
REQ-015 LDI A,imm (0x04), 2 cycles: A<=imm; PC<=PC+1.
REQ-016 JMP addr (0x05), 2 cycles: PC<=operand byte; next fetch from that address.
REQ-017 AND imm (0x06) and OR imm (0x07), 2 cycles: A<=A&imm or A|imm; C unchanged; PC<=PC+1.
REQ-018 Z SHALL update to (new A==0) whenever A is written; C changes only on ADD/SUB.
REQ-019 A updates at the rising edge that ends the instruction's final cycle and is visible immediately after it.
REQ-020 After every final cycle the phase SHALL return to FETCH.
REQ-021 PC SHALL wrap 0xFF->0x00 with no side effect; an operand fetched at 0xFF is read there and PC wraps to 0x00.
REQ-022 The design SHALL not write memory and SHALL not halt; execution continues indefinitely.

Reset
REQ-023 While reset=0: PC=0, IR=0, MAR=0, A_REG=0, Z=0, C=0, phase=FETCH, ADDR_OUT_BUS=0x00, taking effect immediately without a clock edge.
REQ-024 Reset asserted mid-instruction SHALL abandon it with no partial register update.
REQ-025 The first fetch after release SHALL be from address 0x00 on the first rising edge with reset=1.

Verification
REQ-026 Reset, then bytes 00,01,02 -> ADDR_OUT 0 during fetch; NOP takes 2 cycles; ADD fetch at 1, operand at 2; A_REG=0x02 after that edge.
REQ-027 Continue with 02,2A at addresses 3,4 and 0x45 at address 0x2A -> ADDR_OUT 3, 4, then 0x2A; A_REG=0x45 after the 3rd cycle.
REQ-028 Continue with 01,05 at 5,6 -> ADDR_OUT=5 on fetch; A_REG=0x4A (74); next fetch address 7.
REQ-029 LDI 0xF0 then ADD 0x20 -> A_REG=0x10, C=1, Z=0; then SUB 0x10 -> A_REG=0x00, Z=1, C=0.
REQ-030 JMP 0x80 -> next ADDR_OUT in FETCH=0x80; PC at 0xFF fetching a NOP -> next fetch at 0x00.
REQ-031 reset=0 during the MEM cycle of LOD -> ADDR_OUT=0 and A_REG=0 immediately, with no load of the in-flight data.
